note_playback_sequencer: RTL

- Records decoded keyboard notes (note code plus octave) into a small buffer.
- On a playback request, replays the buffer in order: each note is held for a fixed duration, followed by a fixed silent gap.
- Sits between convert_keyboard_input and datapath.
- Drives the note/octave/enable that the datapath turns into the audio frequency word.

---
 rtl/note_playback_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/note_playback_sequencer.sv
// Note recorder/player between keyboard decode and the audio datapath.
// Define LOOP_PLAYBACK_EN to repeat the buffer until stop or playback release.
module note_playback_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic              playback,
  input  logic              stop,
  input  logic              clear,
  input  logic [3:0]        note_in,
  input  logic [1:0]        octave_in,
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic              note_valid,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [ADDR_W-1:0] play_idx
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [5:0]        mem [DEPTH];
  logic              prev_load_n;
  logic              prev_playback;
  logic [31:0]       tick;
  logic              load_fall;
  logic              play_rise;
  logic              wr_en;
  logic              last;
  logic              halt;
  logic [ADDR_W:0]   count_nx;
  logic [5:0]        slot0;
  logic [5:0]        slot_nx;
  logic [ADDR_W-1:0] idx_nx;

  assign load_fall = prev_load_n & ~load_n;
  assign play_rise = ~prev_playback & playback;
  assign full      = (count == FULL_CNT);
  assign busy      = (state != IDLE);
  assign wr_en     = (state == IDLE) & load_fall & ~clear & ~full;
  assign count_nx  = clear ? '0
                   : count + {{ADDR_W{1'b0}}, wr_en};
  // A note recorded on the same edge as play_rise must be playable
  assign slot0     = (wr_en && count == '0) ?
                     {note_in, octave_in} : mem[0];
  assign idx_nx    = play_idx + ADDR_W'(1);
  assign slot_nx   = mem[idx_nx];
  assign last      = ({1'b0, play_idx} == count - (ADDR_W+1)'(1));

`ifdef LOOP_PLAYBACK_EN
  assign halt = stop | (prev_playback & ~playback);
`else
  assign halt = stop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[count[ADDR_W-1:0]] <= {note_in, octave_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      play_idx      <= '0;
      tick          <= '0;
      note_out      <= '0;
      octave_out    <= '0;
      note_valid    <= 1'b0;
      prev_load_n   <= 1'b0;
      prev_playback <= 1'b1;
    end else begin
      prev_load_n   <= load_n;
      prev_playback <= playback;
      unique case (state)
        IDLE: begin
          count <= count_nx;
          if (play_rise && count_nx != '0) begin
            state                  <= PLAY;
            play_idx               <= '0;
            tick                   <= '0;
            {note_out, octave_out} <= slot0;
            note_valid             <= 1'b1;
          end
        end
        PLAY: begin
          if (halt) begin
            state      <= IDLE;
            tick       <= '0;
            play_idx   <= '0;
            note_valid <= 1'b0;
          end else if (tick == NOTE_LAST) begin
            state      <= GAP;
            tick       <= '0;
            note_valid <= 1'b0;
          end else begin
            tick <= tick + 32'd1;
          end
        end
        GAP: begin
          if (halt) begin
            state      <= IDLE;
            tick       <= '0;
            play_idx   <= '0;
            note_valid <= 1'b0;
          end else if (tick == GAP_LAST) begin
            tick <= '0;
            if (last) begin
              play_idx <= '0;
`ifdef LOOP_PLAYBACK_EN
              state                  <= PLAY;
              {note_out, octave_out} <= mem[0];
              note_valid             <= 1'b1;
`else
              state <= IDLE;
`endif
            end else begin
              state                  <= PLAY;
              play_idx               <= idx_nx;
              {note_out, octave_out} <= slot_nx;
              note_valid             <= 1'b1;
            end
          end else begin
            tick <= tick + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
